pipe_ctrl: RTL and testbench
============================

# pipe_ctrl

Pipeline sequencing controller for the 10-bit, four-stage core (IF, ID, EXM, WB). It drives the load enables and bubble inserts of the PC, IF/ID, ID/EX and EXM/WB pipeline registers. It resolves three conditions: register data hazards (by forwarding or stalling), taken-branch squashes, and multi-cycle RAM accesses through a request/ready handshake with a timeout watchdog. It also keeps a saturating stall-cycle counter for bring-up.

## Interface
- MEM_TIMEOUT, default 15: maximum number of EXM cycles a RAM access may wait for `ram_ready` before the error trap. Legal range is 1..255.
- clk  in  1  core clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- id_rs1_addr, id_rs2_addr  in  3 each  source register addresses of the instruction in ID.
- id_rs1_used, id_rs2_used  in  1 each  the corresponding source is read.
- ex_rs1_addr, ex_rs2_addr  in  3 each  source addresses held in the ID/EX register.
- ex_rd_addr  in  3  destination address of the instruction in EXM.
- ex_reg_wb  in  1  the instruction in EXM writes a GP register.
- wb_rd_addr  in  3  destination address held in the EXM/WB register.
- wb_reg_wb  in  1  write-back valid in WB.
- wb_mem_read  in  1  the WB value comes from RAM data, not the ALU result.
- ex_branch_taken  in  1  branch resolved taken in EXM.
- ram_req  in  1  the instruction in EXM accesses RAM.
- ram_ready  in  1  RAM completes the access this cycle.
- pc_en, ifid_en, idex_en  out  1 each  register load enables.
- ifid_flush, idex_flush, exwb_flush  out  1 each  load a bubble (all write/valid bits 0) instead of data.
- fwd_a_sel, fwd_b_sel  out  2 each  EXM operand source select.
- mem_timeout  out  1  sticky error flag.
- stall_cycles  out  16  saturating count of cycles with `pc_en`=0 in RUN/MEM_WAIT.

## Operation
- States: RUN, MEM_WAIT, ERROR.
- **RUN**
  - Default outputs: all enables 1, all flushes 0.
  - If `ram_req`=1 and `ram_ready`=0, go to MEM_WAIT and load the wait counter with 1.
- **MEM_WAIT**
  - `pc_en`, `ifid_en`, `idex_en` = 0 and `exwb_flush`=1, so WB receives bubbles and the EXM instruction and its inputs stay frozen.
  - On `ram_ready`=1: return to RUN; that cycle behaves as RUN with the access complete.
  - Otherwise the counter increments. When it reaches MEM_TIMEOUT with no ready, go to ERROR.
- **ERROR**
  - All enables 0, all flushes 1, `mem_timeout`=1.
  - Exit only through reset.
- **Branch (RUN):** `ex_branch_taken`=1 drives `ifid_flush`=1 and `idex_flush`=1 for one cycle. The PC still loads the target.
- **Data stall (RUN, only when PIPE_FWD_EN is undefined):**
  - Stall condition: a used ID source equals `ex_rd_addr` with `ex_reg_wb`=1, or equals `wb_rd_addr` with `wb_reg_wb`=1.
  - Stall response: `pc_en`=`ifid_en`=0 and `idex_flush`=1.
  - Register r0 is not special; address 0 compares like any other.
- **Priority:** ERROR > MEM_WAIT > branch flush > data stall. A branch squashes any pending data stall in the same cycle.
  - If `ram_req` and `ex_branch_taken` are both high, MEM_WAIT wins. The branch flush is issued in the cycle `ram_ready` arrives.
- **Forward selects** (2'b00 = register file, 2'b01 = WB ALU result, 2'b10 = WB RAM data):
  - Select is nonzero when the EX source address equals `wb_rd_addr` and `wb_reg_wb`=1.
  - Between the two nonzero codes, `wb_mem_read` chooses.
  - Selects are forced to 00 in ERROR and when forwarding is compiled out.
- **stall_cycles:** increments on every cycle in RUN or MEM_WAIT with `pc_en`=0, and saturates at 16'hFFFF.

## Timing
- Enables, flushes and forward selects are combinational from the current state and inputs, valid in the same cycle. There is no added latency.
- A data stall lasts until the hazard clears: at most 2 cycles for a producer in EXM, 1 for a producer in WB.
- The minimum RAM wait is 1 cycle (ready in the cycle of the request means no wait state).
- ERROR is entered on the edge after wait cycle MEM_TIMEOUT.
- While `reset`=0:
  - state RUN, counters 0, `mem_timeout`=0;
  - outputs `pc_en`=`ifid_en`=`idex_en`=0, `ifid_flush`=`idex_flush`=`exwb_flush`=1, selects 00.
- Normal RUN outputs begin in the first cycle after deassertion.
- Reset asserted in MEM_WAIT or ERROR returns to RUN immediately (asynchronously).

## Configuration
- PIPE_FWD_EN defined:
  - forward-select logic is present;
  - no data stalls are generated.
- PIPE_FWD_EN undefined:
  - forward selects are tied to 00;
  - the ID-stage RAW stall logic above is present.

## Structure
- `pipe_ctrl_pkg` holds the state enum (RUN, MEM_WAIT, ERROR), the FWD_RF/FWD_ALU/FWD_RAM select constants, and the 3-bit register-address width.
- One sub-module, `mem_wait_timer`, contains the wait counter. Its ports are start, ready and clear in, and expired out; its counter width is $clog2(MEM_TIMEOUT+1).

## Test plan
- Reset released, NOP stream, no requests → all enables 1, flushes 0, `stall_cycles`=0 after 20 cycles.
- `ram_req`=1 with `ram_ready` arriving on the 3rd cycle → front-end enables low for 2 cycles, `exwb_flush` high for 2 cycles, `stall_cycles`=2.
- `ram_req`=1 with ready never arriving, MEM_TIMEOUT=4 → ERROR after 4 wait cycles, `mem_timeout` stays 1 until reset, then clears.
- `ex_branch_taken`=1 in the same cycle as an ID hazard on r3 → one cycle of `ifid_flush`=`idex_flush`=1 and `pc_en`=1, no stall.
- With PIPE_FWD_EN: `wb_rd_addr`=5, `wb_reg_wb`=1, `wb_mem_read`=1, `ex_rs2_addr`=5 → `fwd_b_sel`=2'b10, `fwd_a_sel`=00.
- Without PIPE_FWD_EN: ID reads r2 while EXM writes r2 → `pc_en`=0 for 2 cycles with `idex_flush`=1, then resume.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg -- shared types and constants for the pipeline sequencing
// controller of the 10-bit, four-stage core (IF, ID, EXM, WB).
//
// Contents:
//   REG_ADDR_W      width of a general-purpose register address
//   reg_addr_t      register address type
//   state_t         controller states RUN / MEM_WAIT / ERROR
//   FWD_RF/ALU/RAM  EXM operand source select codes
//   src_hit()       "this source reads what that producer writes"
//   fwd_select()    forward-select code for one EXM operand

package pipe_ctrl_pkg;

  localparam int REG_ADDR_W = 3;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_t;

  localparam logic [1:0] FWD_RF  = 2'b00;  // register file read
  localparam logic [1:0] FWD_ALU = 2'b01;  // ALU result held in EXM/WB
  localparam logic [1:0] FWD_RAM = 2'b10;  // RAM data held in EXM/WB

  // r0 is an ordinary register in this core, so address 0 compares normally.
  function automatic logic src_hit(input logic      used,
                                   input reg_addr_t src,
                                   input reg_addr_t dst,
                                   input logic      dst_wb);
    return used && dst_wb && (src == dst);
  endfunction

  function automatic logic [1:0] fwd_select(input reg_addr_t src,
                                            input reg_addr_t wb_rd,
                                            input logic      wb_reg_wb,
                                            input logic      wb_mem_read);
    if (src_hit(1'b1, src, wb_rd, wb_reg_wb)) begin
      return wb_mem_read ? FWD_RAM : FWD_ALU;
    end
    return FWD_RF;
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer -- counts EXM cycles spent waiting on a RAM access.
//
// Parameters:
//   MEM_TIMEOUT  number of wait cycles allowed before expiry (1..255)
// Ports:
//   clk      core clock
//   reset    asynchronous, active-low reset
//   start    access just went pending: load the counter with 1
//   ready    RAM completed the access: counter returns to 0
//   clear    force the counter to 0 (highest priority)
//   expired  the current wait cycle is number MEM_TIMEOUT

module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic ready,
  input  logic clear,
  output logic expired
);

  localparam int                CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LIMIT = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0]  ONE   = CNT_W'(1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (start) begin
      count <= ONE;
    end else if (ready) begin
      count <= '0;
    end else if (count != '0 && count != LIMIT) begin
      // Holds at LIMIT; the controller leaves MEM_WAIT on that edge anyway.
      count <= count + ONE;
    end
  end

  assign expired = (count == LIMIT);

endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline sequencing controller for the 10-bit, four-stage
// core. Drives the PC / IF/ID / ID/EX load enables, the bubble inserts of
// IF/ID, ID/EX and EXM/WB, and the EXM operand forward selects. Resolves
// RAM waits (with a timeout trap), taken-branch squashes and RAW hazards.
//
// Build option:
//   PIPE_FWD_EN  defined   -> forward selects from WB, no data stalls
//                undefined -> selects tied to FWD_RF, ID-stage RAW stalls
//
// Parameters:
//   MEM_TIMEOUT  max wait cycles for ram_ready before ERROR (1..255)
// Ports:
//   clk, reset                     clock, async active-low reset
//   id_rs1/rs2_addr, _used         ID-stage source operands
//   ex_rs1/rs2_addr                sources held in ID/EX (forwarding)
//   ex_rd_addr, ex_reg_wb          EXM-stage producer
//   wb_rd_addr, wb_reg_wb          WB-stage producer
//   wb_mem_read                    WB value is RAM data
//   ex_branch_taken                branch resolved taken in EXM
//   ram_req, ram_ready             RAM access handshake
//   pc_en, ifid_en, idex_en        register load enables
//   ifid/idex/exwb_flush           bubble inserts
//   fwd_a_sel, fwd_b_sel           EXM operand source selects
//   mem_timeout                    sticky RAM timeout error
//   stall_cycles                   saturating count of pc_en=0 cycles

module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic                  id_rs1_used,
  input  logic                  id_rs2_used,
  input  logic [REG_ADDR_W-1:0] ex_rs1_addr,
  input  logic [REG_ADDR_W-1:0] ex_rs2_addr,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic                  ex_reg_wb,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  wb_reg_wb,
  input  logic                  wb_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  ram_req,
  input  logic                  ram_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exwb_flush,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  mem_timeout,
  output logic [15:0]           stall_cycles
);

  state_t     state;
  state_t     next_state;
  logic       mem_pending;
  logic       timer_expired;
  logic       data_hazard;
  logic [1:0] fwd_a_raw;
  logic [1:0] fwd_b_raw;

  // An outstanding access freezes the front end in the request cycle too,
  // otherwise ID/EX would overwrite the instruction still waiting in EXM.
  assign mem_pending = ram_req && !ram_ready;

  mem_wait_timer #(
    .MEM_TIMEOUT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk     (clk),
    .reset   (reset),
    .start   ((state == RUN) && mem_pending),
    .ready   (ram_ready),
    .clear   (state == ERROR),
    .expired (timer_expired)
  );

  // ------------------------------------------------------------------
  // Hazard detection / forwarding (build-time choice)
  // ------------------------------------------------------------------
`ifdef PIPE_FWD_EN
  always_comb begin
    fwd_a_raw   = fwd_select(ex_rs1_addr, wb_rd_addr, wb_reg_wb, wb_mem_read);
    fwd_b_raw   = fwd_select(ex_rs2_addr, wb_rd_addr, wb_reg_wb, wb_mem_read);
    data_hazard = 1'b0;
  end

  // ID-stage sources only matter to the stall logic of the other build.
  logic unused_id_srcs;
  assign unused_id_srcs = ^{id_rs1_addr, id_rs2_addr, id_rs1_used,
                            id_rs2_used, ex_rd_addr, ex_reg_wb};
`else
  always_comb begin
    fwd_a_raw   = FWD_RF;
    fwd_b_raw   = FWD_RF;
    data_hazard = src_hit(id_rs1_used, id_rs1_addr, ex_rd_addr, ex_reg_wb) ||
                  src_hit(id_rs1_used, id_rs1_addr, wb_rd_addr, wb_reg_wb) ||
                  src_hit(id_rs2_used, id_rs2_addr, ex_rd_addr, ex_reg_wb) ||
                  src_hit(id_rs2_used, id_rs2_addr, wb_rd_addr, wb_reg_wb);
  end

  // EX-stage sources and the RAM/ALU flag only feed the forwarding muxes.
  logic unused_fwd_srcs;
  assign unused_fwd_srcs = ^{ex_rs1_addr, ex_rs2_addr, wb_mem_read};
`endif

  // ------------------------------------------------------------------
  // State register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= RUN;
    end else begin
      state <= next_state;
    end
  end

  // ------------------------------------------------------------------
  // Next state and outputs
  // ------------------------------------------------------------------
  // NOTE: every output of this block gets a default before any branch, so
  // no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    next_state  = state;
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exwb_flush  = 1'b0;
    fwd_a_sel   = fwd_a_raw;
    fwd_b_sel   = fwd_b_raw;
    mem_timeout = 1'b0;

    case (state)
      RUN: begin
        if (mem_pending) next_state = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (ram_ready)          next_state = RUN;
        else if (timer_expired) next_state = ERROR;
      end
      ERROR: begin
        next_state = ERROR;
      end
      default: begin
        next_state = RUN;
      end
    endcase

    // Priority: reset > ERROR > RAM wait > branch squash > data stall.
    // A MEM_WAIT cycle that sees ram_ready falls through to RUN behaviour.
    if (!reset) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
      exwb_flush = 1'b1;
      fwd_a_sel  = FWD_RF;
      fwd_b_sel  = FWD_RF;
    end else if (state == ERROR) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exwb_flush  = 1'b1;
      fwd_a_sel   = FWD_RF;
      fwd_b_sel   = FWD_RF;
      mem_timeout = 1'b1;
    end else if (mem_pending) begin
      // EXM and its operands stay frozen; WB receives bubbles.
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_en    = 1'b0;
      exwb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      // PC still loads the target; the two younger instructions are squashed.
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (data_hazard) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Bring-up stall counter
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (state != ERROR && !pc_en && stall_cycles != 16'hFFFF) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl -- directed self-checking bench for pipe_ctrl (MEM_TIMEOUT=4).
// Expected values are hand-derived; the PIPE_FWD_EN build changes the
// expectations of the hazard and forwarding vectors.

module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int TIMEOUT = 4;

  // {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exwb_flush}
  localparam logic [5:0] C_RUN  = 6'b111_000;
  localparam logic [5:0] C_HALT = 6'b000_111;  // reset and ERROR
  localparam logic [5:0] C_MEM  = 6'b000_001;
  localparam logic [5:0] C_BR   = 6'b111_110;
`ifdef PIPE_FWD_EN
  localparam logic [5:0] C_STALL   = C_RUN;
  localparam int         STALL_INC = 0;
  localparam logic [1:0] EXP_RAM   = FWD_RAM;
  localparam logic [1:0] EXP_ALU   = FWD_ALU;
`else
  localparam logic [5:0] C_STALL   = 6'b001_010;
  localparam int         STALL_INC = 1;
  localparam logic [1:0] EXP_RAM   = FWD_RF;
  localparam logic [1:0] EXP_ALU   = FWD_RF;
`endif

  logic            clk;
  logic            reset;
  logic [2:0]      id_rs1_addr, id_rs2_addr;
  logic            id_rs1_used, id_rs2_used;
  logic [2:0]      ex_rs1_addr, ex_rs2_addr, ex_rd_addr;
  logic            ex_reg_wb;
  logic [2:0]      wb_rd_addr;
  logic            wb_reg_wb, wb_mem_read;
  logic            ex_branch_taken, ram_req, ram_ready;
  logic            pc_en, ifid_en, idex_en;
  logic            ifid_flush, idex_flush, exwb_flush;
  logic [1:0]      fwd_a_sel, fwd_b_sel;
  logic            mem_timeout;
  logic [15:0]     stall_cycles;
  logic [5:0]      ctrl;

  int n_checks = 0;
  int n_errors = 0;
  int exp_stalls = 0;

  assign ctrl = {pc_en, ifid_en, idex_en, ifid_flush, idex_flush, exwb_flush};

  pipe_ctrl #(
    .MEM_TIMEOUT (TIMEOUT)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_rs1_used     (id_rs1_used),
    .id_rs2_used     (id_rs2_used),
    .ex_rs1_addr     (ex_rs1_addr),
    .ex_rs2_addr     (ex_rs2_addr),
    .ex_rd_addr      (ex_rd_addr),
    .ex_reg_wb       (ex_reg_wb),
    .wb_rd_addr      (wb_rd_addr),
    .wb_reg_wb       (wb_reg_wb),
    .wb_mem_read     (wb_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .ram_req         (ram_req),
    .ram_ready       (ram_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .exwb_flush      (exwb_flush),
    .fwd_a_sel       (fwd_a_sel),
    .fwd_b_sel       (fwd_b_sel),
    .mem_timeout     (mem_timeout),
    .stall_cycles    (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic idle();
    id_rs1_addr = '0; id_rs2_addr = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rs1_addr = '0; ex_rs2_addr = '0; ex_rd_addr = '0;  ex_reg_wb = 1'b0;
    wb_rd_addr = '0;  wb_reg_wb = 1'b0; wb_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ram_req = 1'b0; ram_ready = 1'b0;
  endtask

  // Inputs change at the falling edge; outputs are sampled 1 time unit later.
  initial begin
    reset = 1'b0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    check("rst_ctrl",    32'(ctrl), 32'(C_HALT));
    check("rst_sel",     32'({fwd_a_sel, fwd_b_sel}), 32'd0);
    check("rst_timeout", 32'(mem_timeout), 32'd0);
    check("rst_stalls",  32'(stall_cycles), 32'd0);

    // Release: RUN outputs immediately, then a quiet NOP stream.
    @(negedge clk); reset = 1'b1; #1;
    check("run_first", 32'(ctrl), 32'(C_RUN));
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #1;
      check("run_nop", 32'(ctrl), 32'(C_RUN));
    end
    check("run_stalls", 32'(stall_cycles), 32'd0);

    // RAM access: request cycle + one MEM_WAIT cycle frozen, ready on the 3rd.
    @(negedge clk); ram_req = 1'b1; #1;
    check("mem_req", 32'(ctrl), 32'(C_MEM));
    @(negedge clk); #1;
    check("mem_wait", 32'(ctrl), 32'(C_MEM));
    @(negedge clk); ram_ready = 1'b1; #1;
    check("mem_ready", 32'(ctrl), 32'(C_RUN));
    @(negedge clk); idle(); #1;
    exp_stalls = 2;
    check("mem_after",  32'(ctrl), 32'(C_RUN));
    check("mem_stalls", 32'(stall_cycles), 32'(exp_stalls));

    // Branch squashes a simultaneous r3 hazard.
    @(negedge clk);
    id_rs1_addr = 3'd3; id_rs1_used = 1'b1; ex_rd_addr = 3'd3; ex_reg_wb = 1'b1;
    ex_branch_taken = 1'b1; #1;
    check("br_hazard", 32'(ctrl), 32'(C_BR));
    @(negedge clk); idle(); #1;
    check("br_after",  32'(ctrl), 32'(C_RUN));
    check("br_stalls", 32'(stall_cycles), 32'(exp_stalls));

    // Branch with a pending RAM access: flush deferred to the ready cycle.
    @(negedge clk); ram_req = 1'b1; ex_branch_taken = 1'b1; #1;
    check("brmem_wait", 32'(ctrl), 32'(C_MEM));
    @(negedge clk); ram_ready = 1'b1; #1;
    check("brmem_ready", 32'(ctrl), 32'(C_BR));
    @(negedge clk); idle(); #1;
    exp_stalls += 1;
    check("brmem_after",  32'(ctrl), 32'(C_RUN));
    check("brmem_stalls", 32'(stall_cycles), 32'(exp_stalls));

    // RAW on r2: producer in EXM, then in WB, then gone.
    @(negedge clk);
    id_rs2_addr = 3'd2; id_rs2_used = 1'b1; ex_rd_addr = 3'd2; ex_reg_wb = 1'b1; #1;
    check("raw_ex", 32'(ctrl), 32'(C_STALL));
    @(negedge clk); ex_reg_wb = 1'b0; wb_rd_addr = 3'd2; wb_reg_wb = 1'b1; #1;
    check("raw_wb", 32'(ctrl), 32'(C_STALL));
    @(negedge clk); wb_reg_wb = 1'b0; #1;
    exp_stalls += 2 * STALL_INC;
    check("raw_clear",  32'(ctrl), 32'(C_RUN));
    check("raw_stalls", 32'(stall_cycles), 32'(exp_stalls));

    // r0 compares like any other register; an unused source never stalls.
    @(negedge clk); idle(); id_rs1_used = 1'b1; wb_reg_wb = 1'b1; #1;
    check("raw_r0", 32'(ctrl), 32'(C_STALL));
    @(negedge clk); id_rs1_used = 1'b0; #1;
    exp_stalls += STALL_INC;
    check("raw_unused", 32'(ctrl), 32'(C_RUN));
    check("raw_r0_stalls", 32'(stall_cycles), 32'(exp_stalls));

    // Forward selects.
    @(negedge clk); idle();
    wb_rd_addr = 3'd5; wb_reg_wb = 1'b1; wb_mem_read = 1'b1;
    ex_rs2_addr = 3'd5; ex_rs1_addr = 3'd4; #1;
    check("fwd_b_ram", 32'(fwd_b_sel), 32'(EXP_RAM));
    check("fwd_a_none", 32'(fwd_a_sel), 32'(FWD_RF));
    wb_mem_read = 1'b0; ex_rs1_addr = 3'd5; ex_rs2_addr = 3'd1; #1;
    check("fwd_a_alu", 32'(fwd_a_sel), 32'(EXP_ALU));
    check("fwd_b_none", 32'(fwd_b_sel), 32'(FWD_RF));
    wb_reg_wb = 1'b0; #1;
    check("fwd_no_wb", 32'(fwd_a_sel), 32'(FWD_RF));

    // Timeout: request cycle + TIMEOUT wait cycles, then ERROR.
    @(negedge clk); idle(); ram_req = 1'b1; #1;
    check("to_req", 32'(ctrl), 32'(C_MEM));
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge clk); #1;
      check("to_wait", 32'(ctrl), 32'(C_MEM));
      check("to_wait_flag", 32'(mem_timeout), 32'd0);
    end
    // A forwarding match must not leak a select out of ERROR.
    ex_rs1_addr = 3'd6; wb_rd_addr = 3'd6; wb_reg_wb = 1'b1;
    @(negedge clk); #1;
    exp_stalls += TIMEOUT + 1;
    check("to_error", 32'(ctrl), 32'(C_HALT));
    check("to_flag",  32'(mem_timeout), 32'd1);
    check("to_sel",   32'({fwd_a_sel, fwd_b_sel}), 32'd0);
    check("to_stalls", 32'(stall_cycles), 32'(exp_stalls));
    @(negedge clk); ram_ready = 1'b1; #1;
    check("to_sticky", 32'(mem_timeout), 32'd1);
    check("to_sticky_ctrl", 32'(ctrl), 32'(C_HALT));
    check("to_frozen_stalls", 32'(stall_cycles), 32'(exp_stalls));

    // Asynchronous reset from ERROR, away from any clock edge.
    @(negedge clk); #2 reset = 1'b0; #1;
    check("ar_flag",   32'(mem_timeout), 32'd0);
    check("ar_ctrl",   32'(ctrl), 32'(C_HALT));
    check("ar_stalls", 32'(stall_cycles), 32'd0);
    @(negedge clk); idle(); reset = 1'b1; #1;
    check("ar_run", 32'(ctrl), 32'(C_RUN));
    @(negedge clk); #1;
    check("ar_run_flag", 32'(mem_timeout), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

endmodule
